// File: rtl/pcie_txeq_pkg.sv
// Shared types for the PCIe TX equalization preset sweep sequencer.
package pcie_txeq_pkg;

    localparam int PRESET_W    = 4;
    localparam int MAX_PRESETS = 1 << PRESET_W;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        EVAL,
        NEXT,
        FINAL,
        DONE
    } state_e;

    typedef struct packed {
        logic [5:0] pre;
        logic [5:0] post;
    } coef_t;

    // Lowest set bit at or above 'from'; MSB of the result flags that one was found.
    function automatic logic [PRESET_W:0] next_set(input logic [MAX_PRESETS-1:0] mask,
                                                   input int from);
        logic [PRESET_W:0] r;
        r = '0;
        for (int i = MAX_PRESETS - 1; i >= 0; i--) begin
            if (mask[i] && (i >= from)) r = {1'b1, PRESET_W'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/pcie_txeq_coef_tbl.sv
// Preset coefficient table: one synchronous write port, one combinational read port.
module pcie_txeq_coef_tbl
    import pcie_txeq_pkg::*;
#(
    parameter int NUM_PRESETS = 11
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                we_i,
    input  logic [PRESET_W-1:0] waddr_i,
    input  coef_t               wdata_i,
    input  logic [PRESET_W-1:0] raddr_i,
    output coef_t               rdata_o
);

    coef_t mem_q [NUM_PRESETS];

    // NOTE: the table is small and must read back as zero after reset, so every
    // entry sits in a resettable flop rather than an inferred RAM.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_PRESETS; i++) mem_q[i] <= '0;
        end else if (we_i && (int'(waddr_i) < NUM_PRESETS)) begin
            // NOTE: non-blocking assignment for all clocked state, so every flop
            // samples values from before the edge regardless of statement order.
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = (int'(raddr_i) < NUM_PRESETS) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/pcie_txeq_seq.sv
// Sweeps the enabled TX presets through apply/settle/evaluate and re-applies the best one.
module pcie_txeq_seq
    import pcie_txeq_pkg::*;
#(
    parameter int NUM_PRESETS = 11,
    parameter int SETTLE_CYC  = 64,
    parameter int FOM_TIMEOUT = 1024,
    parameter int FOM_W       = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [NUM_PRESETS-1:0] preset_mask_i,
    input  logic                   cfg_we_i,
    input  logic [3:0]             cfg_addr_i,
    input  logic [5:0]             cfg_pre_i,
    input  logic [5:0]             cfg_post_i,
    output logic                   cfg_ready_o,
    output logic                   coef_valid_o,
    output logic [5:0]             coef_pre_o,
    output logic [5:0]             coef_post_o,
    input  logic                   coef_ack_i,
    output logic                   eval_req_o,
    input  logic                   fom_valid_i,
    input  logic [FOM_W-1:0]       fom_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [3:0]             best_preset_o,
    output logic [FOM_W-1:0]       best_fom_o,
    output logic                   timeout_err_o,
    output logic                   empty_err_o
);

    localparam int CNT_MAX = (SETTLE_CYC > FOM_TIMEOUT) ? SETTLE_CYC : FOM_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] FOM_LAST    = CNT_W'(FOM_TIMEOUT - 1);

    state_e                 state_q, state_d;
    logic [NUM_PRESETS-1:0] mask_q, mask_d;
    logic [PRESET_W-1:0]    cur_idx_q, cur_idx_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   best_valid_q, best_valid_d;
    logic [PRESET_W-1:0]    best_idx_q, best_idx_d;
    logic [FOM_W-1:0]       best_fom_q, best_fom_d;
    coef_t                  coef_q, coef_d;
    logic                   coef_valid_q, coef_valid_d;
    logic                   eval_req_q, eval_req_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   cfg_ready_q, cfg_ready_d;
    logic                   terr_q, terr_d;
    logic                   eerr_q, eerr_d;

    logic [PRESET_W:0]      first_hit, next_hit;
    logic [PRESET_W-1:0]    rd_addr;
    coef_t                  rd_data;
    logic [FOM_W-1:0]       cand_fom;

    pcie_txeq_coef_tbl #(.NUM_PRESETS(NUM_PRESETS)) u_tbl (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .we_i    (cfg_we_i && cfg_ready_q),
        .waddr_i (cfg_addr_i),
        .wdata_i ('{pre: cfg_pre_i, post: cfg_post_i}),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    assign first_hit = next_set(MAX_PRESETS'(preset_mask_i), 0);
    assign next_hit  = next_set(MAX_PRESETS'(mask_q), int'(cur_idx_q) + 1);

    // The read port serves whichever entry the next APPLY/FINAL will present.
    always_comb begin
        rd_addr = cur_idx_q;
        if (state_q == IDLE) begin
            rd_addr = first_hit[PRESET_W-1:0];
        end else if (state_q == NEXT) begin
            rd_addr = next_hit[PRESET_W] ? next_hit[PRESET_W-1:0] : best_idx_q;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before the case, so no path can
        // leave one unassigned and infer a latch.
        state_d      = state_q;
        mask_d       = mask_q;
        cur_idx_d    = cur_idx_q;
        cnt_d        = cnt_q;
        best_valid_d = best_valid_q;
        best_idx_d   = best_idx_q;
        best_fom_d   = best_fom_q;
        coef_d       = coef_q;
        coef_valid_d = coef_valid_q;
        eval_req_d   = eval_req_q;
        done_d       = 1'b0;
        terr_d       = terr_q;
        eerr_d       = eerr_q;
        cand_fom     = '0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    mask_d       = preset_mask_i;
                    terr_d       = 1'b0;
                    eerr_d       = 1'b0;
                    best_valid_d = 1'b0;
                    best_idx_d   = '0;
                    best_fom_d   = '0;
                    cnt_d        = '0;
                    if (first_hit[PRESET_W]) begin
                        cur_idx_d    = first_hit[PRESET_W-1:0];
                        coef_d       = rd_data;
                        coef_valid_d = 1'b1;
                        state_d      = APPLY;
                    end else begin
                        eerr_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            APPLY: begin
                if (coef_ack_i) begin
                    coef_valid_d = 1'b0;
                    cnt_d        = '0;
                    state_d      = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d      = '0;
                    eval_req_d = 1'b1;
                    state_d    = EVAL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            EVAL: begin
                if (fom_valid_i || (cnt_q == FOM_LAST)) begin
                    eval_req_d = 1'b0;
                    state_d    = NEXT;
                    cand_fom   = fom_valid_i ? fom_i : '0;
                    if (!fom_valid_i) terr_d = 1'b1;
                    // Strictly greater, so on a tie the earlier (lower) index wins.
                    if (!best_valid_q || (cand_fom > best_fom_q)) begin
                        best_valid_d = 1'b1;
                        best_idx_d   = cur_idx_q;
                        best_fom_d   = cand_fom;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            NEXT: begin
                coef_d       = rd_data;
                coef_valid_d = 1'b1;
                if (next_hit[PRESET_W]) begin
                    cur_idx_d = next_hit[PRESET_W-1:0];
                    state_d   = APPLY;
                end else begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                if (coef_ack_i) begin
                    coef_valid_d = 1'b0;
                    state_d      = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (abort_i && (state_q inside {APPLY, SETTLE, EVAL, NEXT, FINAL})) begin
            coef_valid_d = 1'b0;
            eval_req_d   = 1'b0;
            state_d      = DONE;
        end

        busy_d      = (state_d != IDLE);
        cfg_ready_d = !busy_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            mask_q       <= '0;
            cur_idx_q    <= '0;
            cnt_q        <= '0;
            best_valid_q <= 1'b0;
            best_idx_q   <= '0;
            best_fom_q   <= '0;
            coef_q       <= '0;
            coef_valid_q <= 1'b0;
            eval_req_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cfg_ready_q  <= 1'b1;
            terr_q       <= 1'b0;
            eerr_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            cur_idx_q    <= cur_idx_d;
            cnt_q        <= cnt_d;
            best_valid_q <= best_valid_d;
            best_idx_q   <= best_idx_d;
            best_fom_q   <= best_fom_d;
            coef_q       <= coef_d;
            coef_valid_q <= coef_valid_d;
            eval_req_q   <= eval_req_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cfg_ready_q  <= cfg_ready_d;
            terr_q       <= terr_d;
            eerr_q       <= eerr_d;
        end
    end

    assign cfg_ready_o   = cfg_ready_q;
    assign coef_valid_o  = coef_valid_q;
    assign coef_pre_o    = coef_q.pre;
    assign coef_post_o   = coef_q.post;
    assign eval_req_o    = eval_req_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign best_preset_o = best_idx_q;
    assign best_fom_o    = best_fom_q;
    assign timeout_err_o = terr_q;
    assign empty_err_o   = eerr_q;

endmodule

// File: tb/tb_pcie_txeq_seq.sv
// Scoreboard bench for pcie_txeq_seq with a behavioural PHY answering acks and FOMs.
module tb_pcie_txeq_seq;

    typedef struct packed {
        logic [3:0] preset;
        logic [7:0] fom;
        logic       terr;
        logic       eerr;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        start_i, abort_i;
    logic [10:0] preset_mask_i;
    logic        cfg_we_i;
    logic [3:0]  cfg_addr_i;
    logic [5:0]  cfg_pre_i, cfg_post_i;
    logic        cfg_ready_o, coef_valid_o;
    logic [5:0]  coef_pre_o, coef_post_o;
    logic        coef_ack_i, eval_req_o, fom_valid_i;
    logic [7:0]  fom_i;
    logic        busy_o, done_o;
    logic [3:0]  best_preset_o;
    logic [7:0]  best_fom_o;
    logic        timeout_err_o, empty_err_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb_q[$];
    int   fom_tab[64];
    int   ack_delay = 0;
    int   ack_cnt = 0, fom_cnt = 0;
    int   done_cnt = 0, apply_rounds = 0, eval_rounds = 0, eval_hi = 0;
    logic prev_valid = 1'b0, prev_eval = 1'b0;
    logic [5:0] prev_pre = '0, prev_post = '0;

    pcie_txeq_seq dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .abort_i(abort_i),
        .preset_mask_i(preset_mask_i), .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i),
        .cfg_pre_i(cfg_pre_i), .cfg_post_i(cfg_post_i), .cfg_ready_o(cfg_ready_o),
        .coef_valid_o(coef_valid_o), .coef_pre_o(coef_pre_o), .coef_post_o(coef_post_o),
        .coef_ack_i(coef_ack_i), .eval_req_o(eval_req_o), .fom_valid_i(fom_valid_i),
        .fom_i(fom_i), .busy_o(busy_o), .done_o(done_o), .best_preset_o(best_preset_o),
        .best_fom_o(best_fom_o), .timeout_err_o(timeout_err_o), .empty_err_o(empty_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // PHY: ack after ack_delay cycles of coef_valid; FOM after 3 cycles, keyed by pre-cursor
    // (the table is loaded with pre = preset index). A negative FOM means never respond.
    always @(negedge clk_i) begin
        if (coef_valid_o) begin
            if (ack_cnt == ack_delay) begin
                coef_ack_i = 1'b1;
                ack_cnt    = 0;
            end else begin
                coef_ack_i = 1'b0;
                ack_cnt++;
            end
        end else begin
            coef_ack_i = 1'b0;
            ack_cnt    = 0;
        end
        if (eval_req_o && (fom_tab[coef_pre_o] >= 0)) begin
            if (fom_cnt == 3) begin
                fom_valid_i = 1'b1;
                fom_i       = 8'(fom_tab[coef_pre_o]);
                fom_cnt     = 0;
            end else begin
                fom_valid_i = 1'b0;
                fom_cnt++;
            end
        end else begin
            fom_valid_i = 1'b0;
            fom_cnt     = 0;
        end
    end

    // Coefficients must not move while a request is outstanding.
    always @(negedge clk_i) begin
        if (coef_valid_o && prev_valid) begin
            check("coef_pre_stable", 32'(coef_pre_o), 32'(prev_pre));
            check("coef_post_stable", 32'(coef_post_o), 32'(prev_post));
        end
        if (coef_valid_o && !prev_valid) apply_rounds++;
        if (eval_req_o && !prev_eval) eval_rounds++;
        if (eval_req_o) eval_hi++;
        prev_valid = coef_valid_o;
        prev_eval  = eval_req_o;
        prev_pre   = coef_pre_o;
        prev_post  = coef_post_o;
    end

    always @(negedge clk_i) begin
        exp_t e;
        if (done_o) begin
            done_cnt++;
            check("busy_low_at_done", 32'(busy_o), 32'd0);
            check("cfg_ready_at_done", 32'(cfg_ready_o), 32'd1);
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'(sb_q.size()), 32'd1);
            end else begin
                e = sb_q.pop_front();
                check("best_preset", 32'(best_preset_o), 32'(e.preset));
                check("best_fom", 32'(best_fom_o), 32'(e.fom));
                check("timeout_err", 32'(timeout_err_o), 32'(e.terr));
                check("empty_err", 32'(empty_err_o), 32'(e.eerr));
            end
        end
    end

    task automatic cfg_write(input int addr, input int pre, input int post);
        @(negedge clk_i);
        cfg_we_i   = 1'b1;
        cfg_addr_i = 4'(addr);
        cfg_pre_i  = 6'(pre);
        cfg_post_i = 6'(post);
        @(negedge clk_i);
        cfg_we_i = 1'b0;
    endtask

    task automatic start_sweep(input int mask, input exp_t e);
        @(negedge clk_i);
        start_i       = 1'b1;
        preset_mask_i = 11'(mask);
        sb_q.push_back(e);
        apply_rounds = 0;
        eval_rounds  = 0;
        eval_hi      = 0;
        @(negedge clk_i);
        start_i = 1'b0;
        check("start_to_coef_valid", 32'(coef_valid_o), 32'(mask != 0));
    endtask

    task automatic wait_done(input int bound);
        int c0 = done_cnt;
        int k  = 0;
        while ((done_cnt == c0) && (k < bound)) begin
            @(negedge clk_i);
            #1;
            k++;
        end
        check("done_within_bound", 32'(done_cnt != c0), 32'd1);
    endtask

    initial begin
        int c0;
        for (int i = 0; i < 64; i++) fom_tab[i] = 10 * i;
        rst_n_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; preset_mask_i = '0;
        cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_pre_i = '0; cfg_post_i = '0;
        coef_ack_i = 1'b0; fom_valid_i = 1'b0; fom_i = '0;

        #22;
        check("rst_cfg_ready", 32'(cfg_ready_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_coef_valid", 32'(coef_valid_o), 32'd0);
        check("rst_eval_req", 32'(eval_req_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_best", 32'({best_preset_o, best_fom_o}), 32'd0);
        check("rst_errs", 32'({timeout_err_o, empty_err_o}), 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Full sweep: P5 wins with 200, final re-apply shows P5's coefficients.
        for (int n = 0; n < 11; n++) cfg_write(n, n, 2 * n);
        fom_tab[5] = 200;
        start_sweep(11'h7FF, '{preset: 4'd5, fom: 8'd200, terr: 1'b0, eerr: 1'b0});
        wait_done(5000);
        check("full_eval_rounds", 32'(eval_rounds), 32'd11);
        check("full_apply_rounds", 32'(apply_rounds), 32'd12);
        check("full_final_pre", 32'(coef_pre_o), 32'd5);
        check("full_final_post", 32'(coef_post_o), 32'd10);
        check("full_done_pulses", 32'(done_cnt), 32'd1);
        fom_tab[5] = 50;

        // Empty mask: done two cycles after start, no coefficient request.
        start_sweep(0, '{preset: 4'd0, fom: 8'd0, terr: 1'b0, eerr: 1'b1});
        check("empty_no_early_done", 32'(done_o), 32'd0);
        @(negedge clk_i);
        #1;
        check("empty_done_latency", 32'(done_o), 32'd1);
        check("empty_no_coef_valid", 32'(apply_rounds), 32'd0);

        // Tie at 50 keeps P0; a start while busy must be ignored.
        fom_tab[0] = 50;
        fom_tab[4] = 50;
        start_sweep(11'h011, '{preset: 4'd0, fom: 8'd50, terr: 1'b0, eerr: 1'b0});
        repeat (10) @(negedge clk_i);
        start_i = 1'b1; preset_mask_i = 11'h000;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_done(2000);
        check("tie_eval_rounds", 32'(eval_rounds), 32'd2);
        check("tie_final_pre", 32'(coef_pre_o), 32'd0);
        fom_tab[0] = 0;
        fom_tab[4] = 40;

        // Evaluation timeout on P2.
        fom_tab[2] = -1;
        start_sweep(11'h004, '{preset: 4'd2, fom: 8'd0, terr: 1'b1, eerr: 1'b0});
        wait_done(3000);
        check("timeout_eval_cycles", 32'(eval_hi), 32'd1024);
        check("timeout_final_pre", 32'(coef_pre_o), 32'd2);
        fom_tab[2] = 20;

        // Slow ack (coefficients checked for stability by the monitor), then abort in SETTLE.
        ack_delay = 37;
        start_sweep(11'h002, '{preset: 4'd0, fom: 8'd0, terr: 1'b0, eerr: 1'b0});
        repeat (30) @(negedge clk_i);
        check("slow_ack_still_valid", 32'(coef_valid_o), 32'd1);
        check("slow_ack_pre", 32'(coef_pre_o), 32'd1);
        begin
            int k = 0;
            while (coef_valid_o && (k < 100)) begin
                @(negedge clk_i);
                k++;
            end
            check("slow_ack_accepted", 32'(coef_valid_o), 32'd0);
        end
        repeat (5) @(negedge clk_i);
        abort_i = 1'b1;
        @(negedge clk_i);
        abort_i = 1'b0;
        check("abort_coef_valid", 32'(coef_valid_o), 32'd0);
        check("abort_eval_req", 32'(eval_req_o), 32'd0);
        check("abort_no_early_done", 32'(done_o), 32'd0);
        @(negedge clk_i);
        #1;
        check("abort_done", 32'(done_o), 32'd1);
        check("abort_no_eval", 32'(eval_rounds), 32'd0);
        ack_delay = 0;

        // Reset during EVAL: outputs clear at once and no done pulse follows.
        fom_tab[0] = -1;
        start_sweep(11'h001, '{preset: 4'd0, fom: 8'd0, terr: 1'b0, eerr: 1'b0});
        begin
            int k = 0;
            while (!eval_req_o && (k < 200)) begin
                @(negedge clk_i);
                k++;
            end
            check("reach_eval", 32'(eval_req_o), 32'd1);
        end
        #2 rst_n_i = 1'b0;
        #1;
        check("midrst_eval_req", 32'(eval_req_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        check("midrst_cfg_ready", 32'(cfg_ready_o), 32'd1);
        check("midrst_coef", 32'({coef_valid_o, coef_pre_o, coef_post_o}), 32'd0);
        sb_q.delete();
        c0 = done_cnt;
        repeat (3) @(negedge clk_i);
        check("midrst_no_done", 32'(done_cnt), 32'(c0));
        rst_n_i = 1'b1;
        fom_tab[0] = 0;

        // Table cleared by reset; out-of-range write and writes while busy are dropped.
        cfg_write(11, 63, 63);
        start_sweep(11'h008, '{preset: 4'd3, fom: 8'd0, terr: 1'b0, eerr: 1'b0});
        check("cleared_entry", 32'({coef_pre_o, coef_post_o}), 32'd0);
        check("cfg_ready_busy", 32'(cfg_ready_o), 32'd0);
        cfg_write(3, 9, 9);
        wait_done(500);
        check("busy_write_dropped", 32'({coef_pre_o, coef_post_o}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
